// File: rtl/mem_pkg.sv
// Shared memory-access types for the data-memory path.
//   mem_sz_e     : access size encoding carried by load/store requests
//   dmem_state_e : state encoding of the data-memory responder FSM
//   be_gen()     : byte-enable pattern for a size and byte offset within a word
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_X = 2'd3
  } mem_sz_e;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StWait,
    StResp
  } dmem_state_e;

  localparam int unsigned BytesPerWord = 4;

  // Illegal sizes produce no enables; callers never issue them to the SRAM.
  function automatic logic [BytesPerWord-1:0] be_gen(mem_sz_e sz, logic [1:0] addr_lo);
    logic [BytesPerWord-1:0] be;
    unique case (sz)
      SZ_B:    be = 4'b0001 << addr_lo;
      SZ_H:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-data alignment: picks the addressed byte/half lane out of a 32-bit
// memory word and zero- or sign-extends it to 32 bits. Purely combinational,
// shared by the memory responder and the writeback path.
// Ports:
//   rdata_i  : raw 32-bit word from memory
//   addr_i   : byte offset within the word
//   sz_i     : access size (byte, half, word)
//   sx_i     : 1 = sign-extend, 0 = zero-extend
//   data_o   : aligned, extended load result
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  mem_sz_e     sz_i,
  input  logic        sx_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    unique case (addr_i)
      2'd0:    byte_lane = rdata_i[7:0];
      2'd1:    byte_lane = rdata_i[15:8];
      2'd2:    byte_lane = rdata_i[23:16];
      default: byte_lane = rdata_i[31:24];
    endcase
    half_lane = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    unique case (sz_i)
      SZ_B:    data_o = {{24{sx_i & byte_lane[7]}}, byte_lane};
      SZ_H:    data_o = {{16{sx_i & half_lane[15]}}, half_lane};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time from the memory
// stage, checks alignment and range, runs a single SRAM access, waits out the
// SRAM read latency and returns a one-cycle response.
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   req_valid_i/ready_o   : request handshake (ready only when idle)
//   req_we_i              : 1 = store, 0 = load
//   req_addr_i            : byte address
//   req_sz_i              : 0 byte, 1 half, 2 word, 3 illegal
//   req_sx_i              : sign-extend load result
//   req_wdata_i           : store data, already replicated across lanes
//   resp_valid_o          : one-cycle response pulse
//   resp_rdata_o          : load result (0 for stores and faults)
//   resp_fault_o          : misaligned, illegal-size or out-of-range request
//   sram_*_o, sram_rdata_i: single-port synchronous SRAM interface
module dmem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned WAIT   = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [31:0]       req_addr_i,
  input  logic [1:0]        req_sz_i,
  input  logic              req_sx_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_fault_o,
  output logic              sram_ce_o,
  output logic              sram_we_o,
  output logic [3:0]        sram_be_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  input  logic [31:0]       sram_rdata_i
);

  localparam int unsigned CntW = (WAIT > 0) ? $clog2(WAIT + 1) : 1;

  dmem_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Request fields needed after acceptance.
  logic        we_q, we_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  mem_sz_e     sz_q, sz_d;
  logic        sx_q, sx_d;

  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_fault_q, resp_fault_d;

  // SRAM drive is registered: loaded on the accept edge, so it is live for
  // exactly the ACCESS cycle and cleared on the following edge.
  logic              sram_ce_q, sram_ce_d;
  logic              sram_we_q, sram_we_d;
  logic [3:0]        sram_be_q, sram_be_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [31:0]       sram_wdata_q, sram_wdata_d;

  // Request checks.
  mem_sz_e req_sz;
  logic    range_err;
  logic    align_err;
  logic    req_fault;

  assign req_sz = mem_sz_e'(req_sz_i);

  if (ADDR_W < 30) begin : g_range
    assign range_err = |req_addr_i[31:ADDR_W+2];
  end else begin : g_no_range
    assign range_err = 1'b0;
  end

  always_comb begin
    unique case (req_sz)
      SZ_B:    align_err = 1'b0;
      SZ_H:    align_err = req_addr_i[0];
      SZ_W:    align_err = |req_addr_i[1:0];
      default: align_err = 1'b1;
    endcase
  end

  assign req_fault = align_err | range_err;

  logic [31:0] load_data;

  mem_load_align u_align (
    .rdata_i (sram_rdata_i),
    .addr_i  (addr_lo_q),
    .sz_i    (sz_q),
    .sx_i    (sx_q),
    .data_o  (load_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_lo_d    = addr_lo_q;
    sz_d         = sz_q;
    sx_d         = sx_q;
    resp_rdata_d = resp_rdata_q;
    resp_fault_d = resp_fault_q;
    sram_ce_d    = 1'b0;
    sram_we_d    = 1'b0;
    sram_be_d    = '0;
    sram_addr_d  = '0;
    sram_wdata_d = '0;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          we_d      = req_we_i;
          addr_lo_d = req_addr_i[1:0];
          sz_d      = req_sz;
          sx_d      = req_sx_i;
          if (req_fault) begin
            state_d      = StResp;
            resp_fault_d = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d      = StAccess;
            sram_ce_d    = 1'b1;
            sram_we_d    = req_we_i;
            sram_be_d    = be_gen(req_sz, req_addr_i[1:0]);
            sram_addr_d  = req_addr_i[ADDR_W+1:2];
            sram_wdata_d = req_wdata_i;
          end
        end
      end
      StAccess: begin
        state_d = StWait;
        cnt_d   = CntW'(WAIT);
      end
      StWait: begin
        if (cnt_q == '0) begin
          // Last latency cycle: SRAM read data is valid now.
          state_d      = StResp;
          resp_fault_d = 1'b0;
          resp_rdata_d = we_q ? 32'h0 : load_data;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_lo_q    <= '0;
      sz_q         <= SZ_B;
      sx_q         <= 1'b0;
      resp_rdata_q <= '0;
      resp_fault_q <= 1'b0;
      sram_ce_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_be_q    <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_lo_q    <= addr_lo_d;
      sz_q         <= sz_d;
      sx_q         <= sx_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
      sram_ce_q    <= sram_ce_d;
      sram_we_q    <= sram_we_d;
      sram_be_q    <= sram_be_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  assign req_ready_o  = (state_q == StIdle);
  assign resp_valid_o = (state_q == StResp);
  assign resp_rdata_o = resp_rdata_q;
  assign resp_fault_o = resp_fault_q;
  assign sram_ce_o    = sram_ce_q;
  assign sram_we_o    = sram_we_q;
  assign sram_be_o    = sram_be_q;
  assign sram_addr_o  = sram_addr_q;
  assign sram_wdata_o = sram_wdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with WAIT=0 (a_*) and one
// with WAIT=3 (b_*), each attached to a behavioural SRAM model.
module tb_dmem_responder;
  import mem_pkg::*;

  localparam int unsigned AW = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, va, vb;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_sz;
  logic        req_sx;
  logic [31:0] req_wdata;

  logic a_ready, a_rv, a_fault, a_ce, a_we;
  logic [3:0] a_be;
  logic [AW-1:0] a_addr;
  logic [31:0] a_wdata, a_rdata, a_srd;
  logic b_ready, b_rv, b_fault, b_ce, b_we;
  logic [3:0] b_be;
  logic [AW-1:0] b_addr;
  logic [31:0] b_wdata, b_rdata, b_srd;

  dmem_responder #(.ADDR_W(AW), .WAIT(0)) u_dut_a (
    .clk_i(clk), .rst_i(rst_a), .req_valid_i(va), .req_ready_o(a_ready),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_sz_i(req_sz), .req_sx_i(req_sx),
    .req_wdata_i(req_wdata), .resp_valid_o(a_rv), .resp_rdata_o(a_rdata),
    .resp_fault_o(a_fault), .sram_ce_o(a_ce), .sram_we_o(a_we), .sram_be_o(a_be),
    .sram_addr_o(a_addr), .sram_wdata_o(a_wdata), .sram_rdata_i(a_srd)
  );

  dmem_responder #(.ADDR_W(AW), .WAIT(3)) u_dut_b (
    .clk_i(clk), .rst_i(rst_b), .req_valid_i(vb), .req_ready_o(b_ready),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_sz_i(req_sz), .req_sx_i(req_sx),
    .req_wdata_i(req_wdata), .resp_valid_o(b_rv), .resp_rdata_o(b_rdata),
    .resp_fault_o(b_fault), .sram_ce_o(b_ce), .sram_we_o(b_we), .sram_be_o(b_be),
    .sram_addr_o(b_addr), .sram_wdata_o(b_wdata), .sram_rdata_i(b_srd)
  );

  // SRAM models.
  logic [31:0] mem_a [0:(1<<AW)-1];
  logic [31:0] mem_b [0:(1<<AW)-1];
  logic [31:0] b_pend;
  int          b_cd;
  logic        b_busy = 1'b0;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] w;
    w = o;
    for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = n[8*i +: 8];
    return w;
  endfunction

  // WAIT=0: data valid the cycle after the access.
  always @(posedge clk) begin
    if (a_ce) begin
      if (a_we) mem_a[a_addr] <= merge(mem_a[a_addr], a_wdata, a_be);
      else a_srd <= mem_a[a_addr];
    end
  end

  // WAIT=3: garbage until 4 cycles after the access, then the word.
  always @(posedge clk) begin
    if (b_ce) begin
      if (b_we) mem_b[b_addr] <= merge(mem_b[b_addr], b_wdata, b_be);
      else begin
        b_pend <= mem_b[b_addr];
        b_cd   <= 2;
        b_busy <= 1'b1;
        b_srd  <= 32'hBAD0_BAD0;
      end
    end else if (b_busy) begin
      if (b_cd == 0) begin
        b_srd  <= b_pend;
        b_busy <= 1'b0;
      end else begin
        b_cd <= b_cd - 1;
      end
    end
  end

  // View of the instance under test.
  int sel = 0;
  logic v_ready, v_rv, v_fault, v_ce, v_we;
  logic [3:0] v_be;
  logic [AW-1:0] v_addr;
  logic [31:0] v_wdata, v_rdata;
  assign v_ready = (sel == 0) ? a_ready : b_ready;
  assign v_rv    = (sel == 0) ? a_rv    : b_rv;
  assign v_fault = (sel == 0) ? a_fault : b_fault;
  assign v_ce    = (sel == 0) ? a_ce    : b_ce;
  assign v_we    = (sel == 0) ? a_we    : b_we;
  assign v_be    = (sel == 0) ? a_be    : b_be;
  assign v_addr  = (sel == 0) ? a_addr  : b_addr;
  assign v_wdata = (sel == 0) ? a_wdata : b_wdata;
  assign v_rdata = (sel == 0) ? a_rdata : b_rdata;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Results of the last transaction.
  int          r_lat, r_ce, r_early, r_ready_after;
  logic [31:0] r_rdata, r_swd;
  logic        r_fault, r_swe;
  logic [3:0]  r_be;
  logic [AW-1:0] r_sa;

  task automatic set_valid(input int d, input logic v);
    if (d == 0) va = v; else vb = v;
  endtask

  // Issues one request; cycle k=1 is the cycle right after the handshake edge.
  task automatic run(input int d, input logic we, input logic [31:0] addr,
                     input logic [1:0] sz, input logic sx, input logic [31:0] wd,
                     input bit pulse);
    sel = d;
    @(negedge clk);
    req_we = we; req_addr = addr; req_sz = sz; req_sx = sx; req_wdata = wd;
    chk("ready_before_req", 32'(v_ready), 32'd1);
    set_valid(d, 1'b1);
    @(posedge clk);
    #1 set_valid(d, 1'b0);
    r_lat = -1; r_ce = 0; r_early = 0; r_rdata = 'x; r_fault = 'x;
    r_be = '0; r_sa = '0; r_swe = 1'b0; r_swd = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (v_ce) begin
        r_ce++; r_be = v_be; r_sa = v_addr; r_swe = v_we; r_swd = v_wdata;
      end
      if (v_rv) begin
        r_lat = k; r_rdata = v_rdata; r_fault = v_fault;
        break;
      end
      if (v_ready) r_early++;
      if (pulse) set_valid(d, (k == 2 || k == 3));
    end
    set_valid(d, 1'b0);
    @(negedge clk);
    r_ready_after = int'(v_ready);
  endtask

  task automatic expect_resp(input string tag, input int lat, input logic [31:0] rd,
                             input logic flt, input int ce);
    chk({tag, "_lat"}, 32'(r_lat), 32'(lat));
    chk({tag, "_rdata"}, r_rdata, rd);
    chk({tag, "_fault"}, 32'(r_fault), 32'(flt));
    chk({tag, "_ce_cycles"}, 32'(r_ce), 32'(ce));
    chk({tag, "_ready_early"}, 32'(r_early), 32'd0);
    chk({tag, "_ready_after"}, 32'(r_ready_after), 32'd1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, 32'(v_ready), 32'd1);
    chk({tag, "_resp_valid"}, 32'(v_rv), 32'd0);
    chk({tag, "_resp_fault"}, 32'(v_fault), 32'd0);
    chk({tag, "_resp_rdata"}, v_rdata, 32'd0);
    chk({tag, "_sram_ce"}, 32'(v_ce), 32'd0);
    chk({tag, "_sram_we"}, 32'(v_we), 32'd0);
    chk({tag, "_sram_be"}, 32'(v_be), 32'd0);
    chk({tag, "_sram_addr"}, 32'(v_addr), 32'd0);
    chk({tag, "_sram_wdata"}, v_wdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_err);
    $fatal(1, "watchdog");
  end

  int pulses;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; va = 1'b0; vb = 1'b0;
    req_we = 1'b0; req_addr = '0; req_sz = '0; req_sx = 1'b0; req_wdata = '0;
    repeat (3) @(negedge clk);
    sel = 0;
    chk_idle_outputs("in_reset_a");
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    chk_idle_outputs("after_reset_a");
    sel = 1;
    chk_idle_outputs("after_reset_b");

    // WAIT=0: word store then word load.
    run(0, 1'b1, 32'h100, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0);
    expect_resp("st_w", 3, 32'h0, 1'b0, 1);
    chk("st_w_be", 32'(r_be), 32'hF);
    chk("st_w_addr", 32'(r_sa), 32'h40);
    chk("st_w_we", 32'(r_swe), 32'd1);
    chk("st_w_wdata", r_swd, 32'hDEADBEEF);
    run(0, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 1'b0);
    expect_resp("ld_w", 3, 32'hDEADBEEF, 1'b0, 1);
    chk("ld_w_be", 32'(r_be), 32'hF);
    chk("ld_w_addr", 32'(r_sa), 32'h40);
    chk("ld_w_we", 32'(r_swe), 32'd0);

    // Byte loads with sign/zero extension.
    run(0, 1'b1, 32'h100, 2'd2, 1'b0, 32'h80112233, 1'b0);
    expect_resp("st_w2", 3, 32'h0, 1'b0, 1);
    run(0, 1'b0, 32'h103, 2'd0, 1'b1, 32'h0, 1'b0);
    expect_resp("ld_b_sx", 3, 32'hFFFFFF80, 1'b0, 1);
    chk("ld_b_be", 32'(r_be), 32'h8);
    run(0, 1'b0, 32'h103, 2'd0, 1'b0, 32'h0, 1'b0);
    expect_resp("ld_b_zx", 3, 32'h00000080, 1'b0, 1);
    run(0, 1'b0, 32'h101, 2'd0, 1'b1, 32'h0, 1'b0);
    expect_resp("ld_b1_sx", 3, 32'h00000022, 1'b0, 1);

    // Half store into the upper lane, low half preserved.
    run(0, 1'b1, 32'h102, 2'd1, 1'b0, 32'h5A5A5A5A, 1'b0);
    expect_resp("st_h", 3, 32'h0, 1'b0, 1);
    chk("st_h_be", 32'(r_be), 32'hC);
    chk("st_h_wdata", r_swd, 32'h5A5A5A5A);
    run(0, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 1'b0);
    expect_resp("ld_w_after_h", 3, 32'h5A5A2233, 1'b0, 1);
    run(0, 1'b0, 32'h102, 2'd1, 1'b1, 32'h0, 1'b0);
    expect_resp("ld_h_hi", 3, 32'h00005A5A, 1'b0, 1);
    chk("ld_h_hi_be", 32'(r_be), 32'hC);
    run(0, 1'b0, 32'h102, 2'd0, 1'b0, 32'h0, 1'b0);
    expect_resp("ld_b2_zx", 3, 32'h0000005A, 1'b0, 1);
    chk("ld_b2_be", 32'(r_be), 32'h4);
    run(0, 1'b1, 32'h100, 2'd1, 1'b0, 32'hF00DF00D, 1'b0);
    expect_resp("st_h_lo", 3, 32'h0, 1'b0, 1);
    chk("st_h_lo_be", 32'(r_be), 32'h3);
    run(0, 1'b0, 32'h100, 2'd1, 1'b1, 32'h0, 1'b0);
    expect_resp("ld_h_lo_sx", 3, 32'hFFFFF00D, 1'b0, 1);
    run(0, 1'b0, 32'h100, 2'd1, 1'b0, 32'h0, 1'b0);
    expect_resp("ld_h_lo_zx", 3, 32'h0000F00D, 1'b0, 1);

    // Faults: no SRAM cycle, response one cycle after the handshake.
    run(0, 1'b0, 32'h101, 2'd1, 1'b0, 32'h0, 1'b0);
    expect_resp("flt_h_mis", 1, 32'h0, 1'b1, 0);
    run(0, 1'b0, 32'h102, 2'd2, 1'b0, 32'h0, 1'b0);
    expect_resp("flt_w_mis", 1, 32'h0, 1'b1, 0);
    run(0, 1'b1, 32'h100, 2'd3, 1'b0, 32'h11111111, 1'b0);
    expect_resp("flt_sz3", 1, 32'h0, 1'b1, 0);
    run(0, 1'b0, 32'h0001_0000, 2'd2, 1'b0, 32'h0, 1'b0);
    expect_resp("flt_range", 1, 32'h0, 1'b1, 0);
    run(0, 1'b1, 32'h8000_0100, 2'd0, 1'b0, 32'h22222222, 1'b0);
    expect_resp("flt_range_hi", 1, 32'h0, 1'b1, 0);
    run(0, 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 1'b0);
    expect_resp("ld_after_flt", 3, 32'h5A5AF00D, 1'b0, 1);

    // Topmost legal word.
    run(0, 1'b1, 32'h0000_FFFC, 2'd2, 1'b0, 32'hCAFEF00D, 1'b0);
    expect_resp("st_top", 3, 32'h0, 1'b0, 1);
    chk("st_top_addr", 32'(r_sa), 32'h3FFF);
    run(0, 1'b0, 32'h0000_FFFC, 2'd2, 1'b0, 32'h0, 1'b0);
    expect_resp("ld_top", 3, 32'hCAFEF00D, 1'b0, 1);

    // WAIT=3 instance, with valid pulses while busy.
    run(1, 1'b1, 32'h40, 2'd2, 1'b0, 32'h12345678, 1'b0);
    expect_resp("w3_st", 6, 32'h0, 1'b0, 1);
    chk("w3_st_addr", 32'(r_sa), 32'h10);
    run(1, 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 1'b1);
    expect_resp("w3_ld_pulse", 6, 32'h12345678, 1'b0, 1);
    run(1, 1'b0, 32'h41, 2'd0, 1'b1, 32'h0, 1'b0);
    expect_resp("w3_ld_b", 6, 32'h00000056, 1'b0, 1);

    // Reset in the middle of WAIT.
    sel = 1;
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h40; req_sz = 2'd2; req_sx = 1'b0; req_wdata = '0;
    vb = 1'b1;
    @(posedge clk);
    #1 vb = 1'b0;
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    #1 chk_idle_outputs("rst_in_wait");
    @(negedge clk);
    rst_b = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (b_rv) pulses++;
    end
    chk("rst_no_resp", 32'(pulses), 32'd0);
    run(1, 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 1'b0);
    expect_resp("w3_after_rst", 6, 32'h12345678, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the core's load/store port: accepts one request at a time from the pipeline's memory stage and drives a single-port synchronous SRAM. It checks alignment and range, generates byte enables, waits out a configurable SRAM latency, and returns a single-cycle response. For loads, the response carries lane-extracted, optionally sign-extended read data. Store data arrives pre-replicated across byte lanes from the requester and is passed to the SRAM unchanged.

## Interface
- `ADDR_W`, 14: SRAM word-address width. Capacity is 4·2^ADDR_W bytes.
- `WAIT`, 0: extra SRAM read-latency cycles beyond the base 1 cycle.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_sz` in 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_sx` in 1: sign-extend the load result.
- `req_wdata` in 32: store data, already lane-replicated.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_rdata` out 32: load result; 0 for stores and faults.
- `resp_fault` out 1: misaligned, illegal-size or out-of-range request.
- `sram_ce`, `sram_we` out 1 each: SRAM chip enable and write enable.
- `sram_be` out 4: SRAM byte enables.
- `sram_addr` out ADDR_W: SRAM word address, `req_addr[ADDR_W+1:2]`.
- `sram_wdata` out 32: SRAM write data.
- `sram_rdata` in 32: SRAM read data, valid 1+WAIT cycles after a read access with `sram_ce`=1, held until the next access.

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
- `req_ready` = (state == IDLE). No other state accepts a request.
- Handshake: `req_valid & req_ready` at a clock edge latches we, addr, sz, sx and wdata.
- The requester holds its request until ready. `req_valid` may drop without a handshake; nothing is recorded in that case.
- Fault check at acceptance. A fault is raised if any of the following holds:
  - sz = 3;
  - sz = 1 and addr[0] = 1;
  - sz = 2 and addr[1:0] ≠ 0;
  - addr[31:ADDR_W+2] ≠ 0.
- On a fault: IDLE → RESP directly with `resp_fault`=1 and `resp_rdata`=0. No SRAM cycle occurs.
- On a legal request: IDLE → ACCESS.
- ACCESS (exactly 1 cycle):
  - `sram_ce`=1, `sram_we`=we, `sram_addr` from the latched address, `sram_wdata`=wdata.
  - `sram_be`: byte → 1 << addr[1:0]; half → addr[1] ? 1100 : 0011; word → 1111.
  - Then → WAIT.
- WAIT (1+WAIT cycles):
  - A down-counter is loaded with WAIT on entry; leave when it reads 0.
  - On the last WAIT cycle, latch the load result from `sram_rdata`:
    - byte lane addr[1:0];
    - half lane addr[1];
    - word unchanged;
    - zero-extend, or sign-extend when sx = 1.
  - Stores latch 0.
- RESP (1 cycle): `resp_valid`=1, with `resp_rdata`/`resp_fault` from the latched values. Then → IDLE.
- `resp_rdata` and `resp_fault` hold until the next RESP overwrites them. Consumers sample them only while `resp_valid`=1.
- Responses have no backpressure. The requester must stall until `resp_valid`.

## Timing
- Reset values:
  - state = IDLE, so `req_ready`=1;
  - `resp_valid`, `resp_fault`, `sram_ce`, `sram_we` = 0;
  - `sram_be`, `sram_addr`, `sram_wdata`, `resp_rdata` = 0;
  - counter = 0.
- Latency, with the handshake at the edge ending cycle T:
  - ACCESS in T+1;
  - WAIT in T+2 … T+2+WAIT;
  - `resp_valid` in T+3+WAIT;
  - `req_ready` high again in T+4+WAIT.
- Fault latency: `resp_valid` in T+1, `req_ready` in T+2.
- SRAM outputs are registered, so they are active only during ACCESS and 0 in every other state.
- `rst` asserted in any state clears everything to reset values immediately, with no response. An in-flight SRAM write is not guaranteed; it may have completed.

## Structure
- Shared package `mem_pkg`:
  - `mem_sz_e` (SZ_B=0, SZ_H=1, SZ_W=2, SZ_X=3);
  - `dmem_state_e`;
  - function `be_gen(sz, addr[1:0])`.
- Sub-module `mem_load_align`: combinational lane select plus sign/zero extension (rdata, addr[1:0], sz, sx → 32-bit result). The WB path reuses it.
- FSM, counter and latches live in `dmem_responder`.

## Test plan
- WAIT=0. Store word 0xDEADBEEF to 0x100, then load word 0x100 → ACCESS with `sram_be`=1111 and `sram_addr`=0x40; load `resp_valid` exactly 3 cycles after the handshake; `resp_rdata`=0xDEADBEEF.
- Load byte 0x103, sx=1, with memory holding 0x80112233 → `resp_rdata`=0xFFFFFF80. The same load with sx=0 → 0x00000080.
- Store half 0x5A5A (replicated as 0x5A5A5A5A) to 0x102, then load word → `sram_be`=1100; the word reads 0x5A5Axxxx with the low half unchanged.
- Load half at 0x101, load word at 0x102, sz=3, and address 0x0001_0000 with ADDR_W=14 → each gives `resp_fault`=1 one cycle after the handshake, with `sram_ce` never asserted.
- WAIT=3 → `resp_valid` 6 cycles after the handshake. `req_ready` stays low throughout, and `req_valid` pulses during WAIT are ignored.
- Assert `rst` during WAIT → all outputs are 0 except `req_ready`=1; no `resp_valid`; the next request completes normally.
